seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_scan_ctrl_if.sv | 28 ++
 rtl/seg_scan_timer.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and state type for the 7-segment scan controller.
// Holds the FSM state encoding, nibble width and anode-off level.
package seg_pkg;

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_SHOW  = 1'b1;

    localparam int NIB_W = 4;

    localparam logic AN_OFF = 1'b1;

    typedef enum logic {
        S_BLANK = ST_BLANK,
        S_SHOW  = ST_SHOW
    } state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-load and display-drive bundle of the scan controller.
// master: frame source side; slave: the scan controller.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    import seg_pkg::*;

    localparam int IW = $clog2(NUM_DIGITS);

    logic                        load;
    logic [NIB_W*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]       digit_en;
    logic [NIB_W-1:0]            digit_val;
    logic [NUM_DIGITS-1:0]       an;
    logic [IW-1:0]               scan_idx;
    logic                        update_ack;

    modport master (
        output load, digits_in, digit_en,
        input  digit_val, an, scan_idx, update_ack
    );

    modport slave (
        input  load, digits_in, digit_en,
        output digit_val, an, scan_idx, update_ack
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Terminal-count phase timer, restarted from zero after each terminal count.
// Ports: clk, rst (async high), last (final count of phase), tc (terminal).
module seg_scan_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] last,
    output logic          tc
);

    logic [CW-1:0] cnt_q;

    assign tc = (cnt_q == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tc) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-seg scan controller, double-buffered frame.
// Ports: clk, reset (async high), bus (seg_scan_ctrl_if.slave).
// Option: SEG_SCAN_LEADING_ZERO_BLANK_EN darkens leading-zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int FW   = NIB_W * NUM_DIGITS;
    localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ?
                          ON_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] ON_LAST = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         act_q, act_d;
    logic [FW-1:0]         pend_q, pend_d;
    logic                  pv_q, pv_d;
    logic [NIB_W-1:0]      dv_q, dv_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  ack_q, ack_d;

    logic                  tc;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] lz_dark;

    seg_scan_timer #(
        .CW (CW)
    ) u_timer (
        .clk  (clk),
        .rst  (reset),
        .last ((state_q == S_SHOW) ? ON_LAST : BL_LAST),
        .tc   (tc)
    );

    assign frame_end = (state_q == S_SHOW) && tc &&
                       (idx_q == IDX_LAST);

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // Scan down from the top digit; everything above the first
    // nonzero nibble is dark. Digit 0 is never suppressed.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (act_q[i*NIB_W +: NIB_W] != '0) begin
                seen = 1'b1;
            end
            lz_dark[i] = ~seen;
        end
    end
`else
    assign lz_dark = '0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pv_d    = pv_q;
        dv_d    = dv_q;
        ack_d   = 1'b0;
        an_d    = {NUM_DIGITS{AN_OFF}};

        unique case (state_q)
            S_BLANK: begin
                if (tc) begin
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (tc) begin
                    state_d = S_BLANK;
                    idx_d   = (idx_q == IDX_LAST) ?
                              '0 : idx_q + 1'b1;
                end
            end
        endcase

        // The active frame only swaps at the wrap, so a frame
        // is never torn. A load on that exact cycle wins.
        if (frame_end) begin
            if (bus.load) begin
                act_d  = bus.digits_in;
                pend_d = '0;
                pv_d   = 1'b0;
                ack_d  = 1'b1;
            end else if (pv_q) begin
                act_d = pend_q;
                pv_d  = 1'b0;
                ack_d = 1'b1;
            end
        end else if (bus.load) begin
            pend_d = bus.digits_in;
            pv_d   = 1'b1;
        end

        // New nibble is presented while all anodes are dark.
        if ((state_q == S_SHOW) && (state_d == S_BLANK)) begin
            dv_d = act_d[int'(idx_d)*NIB_W +: NIB_W];
        end

        if ((state_d == S_SHOW) && bus.digit_en[idx_d] &&
            !lz_dark[idx_d]) begin
            an_d[idx_d] = ~AN_OFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BLANK;
            idx_q   <= '0;
            act_q   <= '0;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            dv_q    <= '0;
            an_q    <= {NUM_DIGITS{AN_OFF}};
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            dv_q    <= dv_d;
            an_q    <= an_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.digit_val  = dv_q;
    assign bus.an         = an_q;
    assign bus.scan_idx   = idx_q;
    assign bus.update_ack = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a cycle-position model.
// Covers reset, scan timing, frame commit rules, enables, random traffic.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int N  = 4;
    localparam int ON = 4;
    localparam int BL = 2;
    localparam int P  = ON + BL;
    localparam int FR = N * P;
    localparam int IW = $clog2(N);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    // Model: position in the scan is pure arithmetic on the cycle
    // number since reset release; frames are plain values.
    int           m_cyc;
    logic [4*N-1:0] m_act, m_pend;
    logic         m_pv;
    logic [N-1:0] exp_an;
    logic [3:0]   exp_dv;
    logic [IW-1:0] exp_idx;
    logic         exp_ack;

    function automatic bit lz_dark(logic [4*N-1:0] f, int d);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        int hi;
        hi = 0;
        for (int k = 0; k < N; k++)
            if (((f >> (4*k)) & 'hF) != 0) hi = k;
        return d > hi;
`else
        return (f == '1) && (d < 0);
`endif
    endfunction

    task automatic model_reset();
        m_cyc   = 0;
        m_act   = '0;
        m_pend  = '0;
        m_pv    = 1'b0;
        exp_an  = '1;
        exp_dv  = '0;
        exp_idx = '0;
        exp_ack = 1'b0;
    endtask

    task automatic model_step();
        int ph, d, ph2, d2;
        ph = m_cyc % P;
        d  = (m_cyc / P) % N;
        exp_ack = 1'b0;
        if (ph == P - 1 && d == N - 1) begin
            if (bus.load) begin
                m_act = bus.digits_in;
                m_pend = '0;
                m_pv = 1'b0;
                exp_ack = 1'b1;
            end else if (m_pv) begin
                m_act = m_pend;
                m_pv = 1'b0;
                exp_ack = 1'b1;
            end
        end else if (bus.load) begin
            m_pend = bus.digits_in;
            m_pv = 1'b1;
        end
        m_cyc++;
        ph2 = m_cyc % P;
        d2  = (m_cyc / P) % N;
        exp_idx = IW'(d2);
        exp_an = '1;
        if (ph2 >= BL && bus.digit_en[d2] && !lz_dark(m_act, d2))
            exp_an[d2] = 1'b0;
        if (ph2 == 0) exp_dv = m_act[4*d2 +: 4];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic int cycles_to(int d, int ph);
        return ((d * P + ph) - (m_cyc % FR) + FR) % FR;
    endfunction

    function automatic string obs();
        return $sformatf(
            "cyc=%0d an=%b req %b dv=%h req %h idx=%0d req %0d ack=%b req %b",
            m_cyc, bus.an, exp_an, bus.digit_val, exp_dv,
            bus.scan_idx, exp_idx, bus.update_ack, exp_ack);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.load = 1'b0;
        bus.digits_in = '0;
        bus.digit_en = '1;
        repeat (3) @(posedge clk);
        #1;
        assertions++;
        if (bus.an !== 4'b1111) begin
            failures++;
            $display("FAIL reset_an got %b req 1111", bus.an);
        end
        assertions++;
        if (bus.digit_val !== 4'h0) begin
            failures++;
            $display("FAIL reset_dv got %h req 0", bus.digit_val);
        end
        assertions++;
        if (bus.scan_idx !== '0) begin
            failures++;
            $display("FAIL reset_idx got %0d req 0", bus.scan_idx);
        end
        assertions++;
        if (bus.update_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack got %b req 0", bus.update_ack);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_scan_timing();
        int wraps[$];
        logic [IW-1:0] prev;
        logic [N-1:0] want;
        prev = bus.scan_idx;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL scan_timing %s", obs());
            end
            if (i < P - 1) begin
                want = (i + 1 < BL) ? '1 : ~N'(1);
                assertions++;
                if (bus.an !== want) begin
                    failures++;
                    $display("FAIL first_slot_an cyc=%0d got %b req %b",
                             i + 1, bus.an, want);
                end
            end
            if (prev == IW'(N - 1) && bus.scan_idx == '0)
                wraps.push_back(m_cyc);
            prev = bus.scan_idx;
        end
        assertions++;
        if (wraps.size() != 2 || wraps[1] - wraps[0] != FR) begin
            failures++;
            $display("FAIL frame_period wraps=%0d got period %0d req %0d",
                     wraps.size(),
                     (wraps.size() == 2) ? wraps[1] - wraps[0] : -1, FR);
        end
    endtask

    task automatic test_load_mid_frame();
        int off, acks, d;
        bit seen;
        off = cycles_to(1, BL + 1);
        acks = 0;
        seen = 0;
        bus.digits_in = 16'h4321;
        for (int i = 0; i <= off + 2 * FR; i++) begin
            bus.load = (i == off);
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL load_mid %s", obs());
            end
            if (bus.update_ack === 1'b1) begin
                acks++;
                seen = 1;
            end
            d = (m_cyc / P) % N;
            if (seen && (m_cyc % P) >= BL) begin
                assertions++;
                if (bus.digit_val !== 4'(d + 1) ||
                    bus.an !== ~(N'(1) << d)) begin
                    failures++;
                    $display("FAIL load_mid_frame dv=%h an=%b req %h %b",
                             bus.digit_val, bus.an, 4'(d + 1),
                             ~(N'(1) << d));
                end
            end
        end
        bus.load = 1'b0;
        assertions++;
        if (acks != 1) begin
            failures++;
            $display("FAIL load_mid_acks got %0d req 1", acks);
        end
    endtask

    task automatic test_double_load();
        int off, acks;
        bit seen;
        off = cycles_to(0, BL);
        acks = 0;
        seen = 0;
        for (int i = 0; i <= off + 2 * FR; i++) begin
            bus.load = (i == off) || (i == off + 5);
            bus.digits_in = (i == off) ? 16'h1111 : 16'h2222;
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL double_load %s", obs());
            end
            if (bus.update_ack === 1'b1) begin
                acks++;
                seen = 1;
            end
            if (seen && (m_cyc % P) >= BL) begin
                assertions++;
                if (bus.digit_val !== 4'h2) begin
                    failures++;
                    $display("FAIL double_load_dv got %h req 2",
                             bus.digit_val);
                end
            end
        end
        bus.load = 1'b0;
        assertions++;
        if (acks != 1) begin
            failures++;
            $display("FAIL double_load_acks got %0d req 1", acks);
        end
    endtask

    task automatic test_boundary_load();
        int off, acks;
        off = cycles_to(N - 1, P - 1);
        acks = 0;
        bus.digits_in = 16'h5555;
        for (int i = 0; i <= off + 2 * FR; i++) begin
            bus.load = (i == off);
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL boundary_load %s", obs());
            end
            if (bus.update_ack === 1'b1) acks++;
            if (i == off) begin
                assertions++;
                if (bus.update_ack !== 1'b1 ||
                    bus.digit_val !== 4'h5) begin
                    failures++;
                    $display("FAIL boundary_commit ack=%b dv=%h req 1 5",
                             bus.update_ack, bus.digit_val);
                end
            end
        end
        bus.load = 1'b0;
        assertions++;
        if (acks != 1) begin
            failures++;
            $display("FAIL boundary_acks got %0d req 1", acks);
        end
    endtask

    task automatic test_digit_en();
        int off;
        int lows[N];
        off = cycles_to(0, 0);
        foreach (lows[k]) lows[k] = 0;
        bus.digit_en = 4'b1010;
        for (int i = 0; i < off + 2 * FR; i++) begin
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL digit_en %s", obs());
            end
            if (i >= off)
                for (int k = 0; k < N; k++)
                    if (bus.an[k] === 1'b0) lows[k]++;
        end
        bus.digit_en = '1;
        for (int k = 0; k < N; k++) begin
            assertions++;
            if (lows[k] != ((k % 2 == 1) ? 2 * ON : 0)) begin
                failures++;
                $display("FAIL digit_en_count d%0d got %0d req %0d",
                         k, lows[k], (k % 2 == 1) ? 2 * ON : 0);
            end
        end
    endtask

    task automatic test_leading_zero();
        int off, want;
        int lows[N];
        off = cycles_to(0, BL);
        foreach (lows[k]) lows[k] = 0;
        bus.digits_in = 16'h0042;
        for (int i = 0; i < off + 2 * FR; i++) begin
            bus.load = (i == off);
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL leading_zero %s", obs());
            end
            if (i >= off + FR)
                for (int k = 0; k < N; k++)
                    if (bus.an[k] === 1'b0) lows[k]++;
        end
        bus.load = 1'b0;
        for (int k = 0; k < N; k++) begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            want = (k < 2) ? ON : 0;
`else
            want = ON;
`endif
            assertions++;
            if (lows[k] != want) begin
                failures++;
                $display("FAIL leading_zero_count d%0d got %0d req %0d",
                         k, lows[k], want);
            end
        end
    endtask

    task automatic test_reset_mid();
        int off, tot, acks, nz;
        off = cycles_to(0, BL);
        tot = off + 2 * P + 1;
        bus.digits_in = 16'h9876;
        for (int i = 0; i < tot; i++) begin
            bus.load = (i == off);
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL reset_mid_pre %s", obs());
            end
        end
        bus.load = 1'b0;
        assertions++;
        if (bus.scan_idx !== IW'(2) || bus.an !== 4'b1011) begin
            failures++;
            $display("FAIL reset_mid_setup idx=%0d an=%b req 2 1011",
                     bus.scan_idx, bus.an);
        end
        #2 reset = 1'b1;
        #1;
        assertions++;
        if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
            !== {4'b1111, 4'h0, IW'(0), 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_async an=%b dv=%h idx=%0d ack=%b",
                     bus.an, bus.digit_val, bus.scan_idx,
                     bus.update_ack);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        acks = 0;
        nz = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL reset_mid_post %s", obs());
            end
            if (bus.update_ack === 1'b1) acks++;
            if (bus.digit_val !== 4'h0) nz++;
        end
        assertions++;
        if (acks != 0 || nz != 0) begin
            failures++;
            $display("FAIL reset_mid_drop acks=%0d nonzero_dv=%0d req 0 0",
                     acks, nz);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            bus.load = ($urandom_range(0, 19) == 0);
            bus.digits_in = 16'($urandom);
            if ($urandom_range(0, 39) == 0)
                bus.digit_en = N'($urandom_range(0, 15));
            tick();
            assertions++;
            if ({bus.an, bus.digit_val, bus.scan_idx, bus.update_ack}
                !== {exp_an, exp_dv, exp_idx, exp_ack}) begin
                failures++;
                $display("FAIL random %s", obs());
            end
        end
        bus.load = 1'b0;
        bus.digit_en = '1;
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_load_mid_frame();
        test_double_load();
        test_boundary_load();
        test_digit_en();
        test_leading_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
